// File: rtl/and_or_not_pkg.sv
// Shared constants for the and_or_not bitwise logic unit.
// Default operand width and bit positions inside the zero-flag vector.
// No state, no flow control.
package and_or_not_pkg;
    localparam int DEFAULT_WIDTH = 8;
    localparam int NUM_ZF        = 6;

    localparam int ZF_AND  = 0;
    localparam int ZF_OR   = 1;
    localparam int ZF_XOR  = 2;
    localparam int ZF_NAND = 3;
    localparam int ZF_NOR  = 4;
    localparam int ZF_XNOR = 5;
endpackage

// File: rtl/and_or_not_slice.sv
// Purpose: six bitwise logic results of a and b, each bit independent of its neighbours.
// Latency: purely combinational.
// Backpressure: none; the result follows the inputs.
module and_or_not_slice #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] and_r,
    output logic [WIDTH-1:0] or_r,
    output logic [WIDTH-1:0] xor_r,
    output logic [WIDTH-1:0] nand_r,
    output logic [WIDTH-1:0] nor_r,
    output logic [WIDTH-1:0] xnor_r
);
    always_comb begin
        and_r  = a & b;
        or_r   = a | b;
        xor_r  = a ^ b;
        nand_r = ~(a & b);
        nor_r  = ~(a | b);
        xnor_r = ~(a ^ b);
    end
endmodule

// File: rtl/and_or_not.sv
// Purpose: registered AND/OR/XOR/NAND/NOR/XNOR of a and b, plus equality and per-result zero flags.
// Latency: one clock from an in_valid edge to out_valid and the results.
// Backpressure: none; one result set per cycle, results hold while in_valid is low.
module and_or_not
    import and_or_not_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] and_o,
    output logic [WIDTH-1:0] or_o,
    output logic [WIDTH-1:0] xor_o,
    output logic [WIDTH-1:0] nand_o,
    output logic [WIDTH-1:0] nor_o,
    output logic [WIDTH-1:0] xnor_o,
    output logic             eq_o,
    output logic [5:0]       zero_o
);
    logic [WIDTH-1:0] and_w, or_w, xor_w, nand_w, nor_w, xnor_w;

    logic [WIDTH-1:0] and_d, or_d, xor_d, nand_d, nor_d, xnor_d;
    logic [WIDTH-1:0] and_q, or_q, xor_q, nand_q, nor_q, xnor_q;
    logic             eq_d, eq_q;
    logic [NUM_ZF-1:0] zero_d, zero_q;
    logic             out_valid_d, out_valid_q;

    and_or_not_slice #(.WIDTH(WIDTH)) u_slice (
        .a      (a),
        .b      (b),
        .and_r  (and_w),
        .or_r   (or_w),
        .xor_r  (xor_w),
        .nand_r (nand_w),
        .nor_r  (nor_w),
        .xnor_r (xnor_w)
    );

    // Operands are only looked at under in_valid, so unknowns on idle cycles never reach the flops.
    always_comb begin
        and_d       = and_q;
        or_d        = or_q;
        xor_d       = xor_q;
        nand_d      = nand_q;
        nor_d       = nor_q;
        xnor_d      = xnor_q;
        eq_d        = eq_q;
        zero_d      = zero_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            and_d           = and_w;
            or_d            = or_w;
            xor_d           = xor_w;
            nand_d          = nand_w;
            nor_d           = nor_w;
            xnor_d          = xnor_w;
            eq_d            = &xnor_w;
            zero_d[ZF_AND]  = ~|and_w;
            zero_d[ZF_OR]   = ~|or_w;
            zero_d[ZF_XOR]  = ~|xor_w;
            zero_d[ZF_NAND] = ~|nand_w;
            zero_d[ZF_NOR]  = ~|nor_w;
            zero_d[ZF_XNOR] = ~|xnor_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            and_q       <= '0;
            or_q        <= '0;
            xor_q       <= '0;
            nand_q      <= '0;
            nor_q       <= '0;
            xnor_q      <= '0;
            eq_q        <= 1'b0;
            zero_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            and_q       <= and_d;
            or_q        <= or_d;
            xor_q       <= xor_d;
            nand_q      <= nand_d;
            nor_q       <= nor_d;
            xnor_q      <= xnor_d;
            eq_q        <= eq_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign and_o     = and_q;
    assign or_o      = or_q;
    assign xor_o     = xor_q;
    assign nand_o    = nand_q;
    assign nor_o     = nor_q;
    assign xnor_o    = xnor_q;
    assign eq_o      = eq_q;
    assign zero_o    = zero_q;
endmodule

// File: tb/tb_and_or_not.sv
// Scoreboard bench for and_or_not: a driver queues expected results, a monitor checks them on the falling edge.
module tb_and_or_not;
    localparam int W = 8;

    // Per-bit truth tables indexed by {a[i], b[i]}.
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_XNOR = 4'b1001;

    typedef struct packed {
        logic [W-1:0] and_v;
        logic [W-1:0] or_v;
        logic [W-1:0] xor_v;
        logic [W-1:0] nand_v;
        logic [W-1:0] nor_v;
        logic [W-1:0] xnor_v;
        logic         eq_v;
        logic [5:0]   zero_v;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic [W-1:0] and_o, or_o, xor_o, nand_o, nor_o, xnor_o;
    logic         eq_o;
    logic [5:0]   zero_o;

    int   check_cnt = 0;
    int   pass_cnt  = 0;
    exp_t exp_q[$];
    exp_t exp_next = '0;
    exp_t last_exp = '0;

    always #5 clk = ~clk;

    and_or_not #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .and_o     (and_o),
        .or_o      (or_o),
        .xor_o     (xor_o),
        .nand_o    (nand_o),
        .nor_o     (nor_o),
        .xnor_o    (xnor_o),
        .eq_o      (eq_o),
        .zero_o    (zero_o)
    );

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t r;
        logic [1:0] idx;
        r = '0;
        for (int i = 0; i < W; i++) begin
            idx         = {x[i], y[i]};
            r.and_v[i]  = TT_AND[idx];
            r.or_v[i]   = TT_OR[idx];
            r.xor_v[i]  = TT_XOR[idx];
            r.nand_v[i] = TT_NAND[idx];
            r.nor_v[i]  = TT_NOR[idx];
            r.xnor_v[i] = TT_XNOR[idx];
        end
        r.eq_v      = (x == y);
        r.zero_v[0] = (r.and_v  == 0);
        r.zero_v[1] = (r.or_v   == 0);
        r.zero_v[2] = (r.xor_v  == 0);
        r.zero_v[3] = (r.nand_v == 0);
        r.zero_v[4] = (r.nor_v  == 0);
        r.zero_v[5] = (r.xnor_v == 0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        check_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    endtask

    task automatic chk_outputs(input string tag, input exp_t e, input logic vld);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(vld));
        chk({tag, ".and"},  64'(and_o),  64'(e.and_v));
        chk({tag, ".or"},   64'(or_o),   64'(e.or_v));
        chk({tag, ".xor"},  64'(xor_o),  64'(e.xor_v));
        chk({tag, ".nand"}, 64'(nand_o), 64'(e.nand_v));
        chk({tag, ".nor"},  64'(nor_o),  64'(e.nor_v));
        chk({tag, ".xnor"}, 64'(xnor_o), 64'(e.xnor_v));
        chk({tag, ".eq"},   64'(eq_o),   64'(e.eq_v));
        chk({tag, ".zero"}, 64'(zero_o), 64'(e.zero_v));
    endtask

    // Capture side of the scoreboard: an edge with rst_n high and in_valid high yields one result.
    always @(posedge clk) begin
        if (rst_n && in_valid) exp_q.push_back(exp_next);
    end

    // Monitor: in reset everything is zero; on out_valid pop and compare; otherwise outputs must hold.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk_outputs("reset", exp_t'('0), 1'b0);
            last_exp = '0;
        end else if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 64'(out_valid), 64'd0);
            end else begin
                last_exp = exp_q.pop_front();
                chk_outputs("result", last_exp, 1'b1);
                chk("inv_xor_or_nand", 64'(xor_o), 64'(or_o & nand_o));
            end
        end else begin
            chk_outputs("hold", last_exp, 1'b0);
        end
    end

    typedef struct packed {
        logic [W-1:0] a_v;
        logic [W-1:0] b_v;
        exp_t         e;
    } dir_t;

    dir_t dir_tab[5];

    task automatic drive(input logic vld, input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e);
        in_valid = vld;
        a        = x;
        b        = y;
        exp_next = e;
    endtask

    initial begin
        dir_tab[0] = '{8'h00, 8'h00, '{8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 1'b1, 6'b000111}};
        dir_tab[1] = '{8'h31, 8'h34, '{8'h30, 8'h35, 8'h05, 8'hCF, 8'hCA, 8'hFA, 1'b0, 6'b000000}};
        dir_tab[2] = '{8'h87, 8'h1A, '{8'h02, 8'h9F, 8'h9D, 8'hFD, 8'h60, 8'h62, 1'b0, 6'b000000}};
        dir_tab[3] = '{8'hFE, 8'hFF, '{8'hFE, 8'hFF, 8'h01, 8'h01, 8'h00, 8'hFE, 1'b0, 6'b010000}};
        dir_tab[4] = '{8'h61, 8'h61, '{8'h61, 8'h61, 8'h00, 8'h9E, 8'h9E, 8'hFF, 1'b1, 6'b000100}};

        // Operands presented with in_valid during reset must be ignored.
        drive(1'b1, 8'hA5, 8'h3C, model(8'hA5, 8'h3C));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, '0, '0, '0);
        @(negedge clk);

        // Directed vectors back-to-back, expectations taken straight from the worked examples.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, dir_tab[i].a_v, dir_tab[i].b_v, dir_tab[i].e);
            @(negedge clk);
        end
        // New operands without in_valid: previous results must hold.
        drive(1'b0, 8'h0F, 8'hF0, model(8'h0F, 8'hF0));
        repeat (3) @(negedge clk);

        for (int n = 0; n < 400; n++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            rb = (n % 7 == 0) ? ra : W'($urandom);
            if ($urandom_range(0, 9) < 7) drive(1'b1, ra, rb, model(ra, rb));
            else drive(1'b0, ra, rb, model(ra, rb));

            if (n == 200) begin
                // Reset between edges while a valid operand is waiting to be captured.
                drive(1'b1, ra, rb, model(ra, rb));
                #2;
                rst_n = 1'b0;
                #1;
                chk_outputs("async_reset", exp_t'('0), 1'b0);
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                drive(1'b0, '0, '0, '0);
            end
            @(negedge clk);
        end

        drive(1'b0, '0, '0, '0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule

// File: doc/and_or_not.md
AND_OR_NOT -- requirements
Module: and_or_not

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result bit width (legal range 1..64).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  input  1  operands a/b valid this cycle; capture enable.
REQ-005 Port: a  input  WIDTH  operand A.
REQ-006 Port: b  input  WIDTH  operand B.
REQ-007 Port: out_valid  output  1  high for one cycle when results reflect newly captured operands.
REQ-008 Port: and_o  output  WIDTH  registered a AND b.
REQ-009 Port: or_o  output  WIDTH  registered a OR b.
REQ-010 Port: xor_o  output  WIDTH  registered a XOR b.
REQ-011 Port: nand_o  output  WIDTH  registered NOT(a AND b).
REQ-012 Port: nor_o  output  WIDTH  registered NOT(a OR b).
REQ-013 Port: xnor_o  output  WIDTH  registered NOT(a XOR b).
REQ-014 Port: eq_o  output  1  registered flag, 1 when a == b (xnor all ones).
REQ-015 Port: zero_o  output  6  registered per-result zero flags, bit order {xnor,nor,nand,xor,or,and} (bit 0 = and_o == 0).

Function
REQ-016 All six results SHALL be computed bitwise, bit i depending only on a[i], b[i]; no carries, no cross-bit logic.
REQ-017 Latency SHALL be exactly one clock: operands sampled at edge N with in_valid=1 appear on all result outputs and out_valid after edge N.
REQ-018 When in_valid=0 at an edge, result, eq_o and zero_o registers SHALL hold their previous values and out_valid SHALL be 0.
REQ-019 Back-to-back in_valid=1 SHALL give one result set per cycle, no bubbles; out_valid stays high continuously.
REQ-020 eq_o SHALL equal AND-reduction of the xnor result computed from the same operands.
REQ-021 zero_o[k] SHALL equal NOR-reduction of the corresponding result computed from the same operands.
REQ-022 Invariants at every output update: nand_o = ~and_o, nor_o = ~nor complement of or_o, xnor_o = ~xor_o, xor_o = or_o & nand_o.
REQ-023 X/unknown on a or b with in_valid=0 SHALL not affect outputs.

Reset
REQ-024 While rst_n=0, all outputs (including nand_o, nor_o, xnor_o, eq_o, zero_o) SHALL be 0 and out_valid 0, asynchronously.
REQ-025 Reset asserted mid-stream SHALL discard the operands sampled in that cycle; first valid result follows the first in_valid=1 edge after rst_n release.

Structure
REQ-026 Shared package and_or_not_pkg SHALL hold default WIDTH constant and zero-flag bit index constants (ZF_AND=0 .. ZF_XNOR=5).
REQ-027 One combinational sub-module and_or_not_slice SHALL compute the six WIDTH-bit results from a, b; top level holds the registers, eq and zero flag logic.

Verification
REQ-028 Reset then a=00000000, b=00000000, in_valid=1 -> next cycle and=00, or=00, xor=00, nand=FF, nor=FF, xnor=FF, eq_o=1, zero_o=000111.
REQ-029 a=00110001, b=00110100 -> and=00110000, or=00110101, xor=00000101, nand=11001111, nor=11001010, xnor=11111010, eq_o=0.
REQ-030 a=10000111, b=00011010 -> and=00000010, or=10011111, xor=10011101, nand=11111101, nor=01100000, xnor=01100010.
REQ-031 a=11111110, b=11111111 -> and=FE, or=FF, xor=01, nand=01, nor=00, xnor=FE, zero_o=010000.
REQ-032 a=b=01100001 -> xor=00, xnor=FF, nand=nor=10011110, eq_o=1; then in_valid=0 with new operands -> outputs hold, out_valid=0.
REQ-033 Assert rst_n=0 between edges during a stream -> all outputs 0 immediately; no stale result after release.
